// File: rtl/mem_arb.sv
// mem_arb: four-port arbiter in front of a single 8-bit asynchronous RAM.
// Port 0 has absolute priority; ports 1..3 share a round-robin pointer.
module mem_arb #(
  parameter int ACC_CYC = 4,
  parameter int AW      = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [31:0]     dati,
  output logic [3:0]      ack,
  output logic [7:0]      rdat,
  output logic            busy,
  output logic [AW-1:0]   ram_addr,
  output logic [7:0]      ram_dati,
  input  logic [7:0]      ram_dato,
  output logic            ram_ce,
  output logic            ram_oe,
  output logic            ram_we
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LD = 4'(ACC_CYC - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [1:0] rr_ptr;
  logic [1:0] win;
  logic [1:0] pick;
  logic       we_lat;

  function automatic logic [1:0] first3(
    input logic [3:0] r,
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c
  );
    if (r[a]) return a;
    else if (r[b]) return b;
    else return c;
  endfunction

  always_comb begin
    pick = 2'd0;
    if (!req[0]) begin
      unique case (rr_ptr)
        2'd1:    pick = first3(req, 2'd1, 2'd2, 2'd3);
        2'd2:    pick = first3(req, 2'd2, 2'd3, 2'd1);
        default: pick = first3(req, 2'd3, 2'd1, 2'd2);
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = ACC;
      ACC:     if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rr_ptr   <= 2'd1;
      win      <= 2'd0;
      we_lat   <= 1'b0;
      ram_addr <= '0;
      ram_dati <= 8'h00;
      rdat     <= 8'hFF;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (|req) begin
            win      <= pick;
            we_lat   <= we[pick];
            ram_addr <= addr[pick*AW +: AW];
            ram_dati <= dati[pick*8 +: 8];
            cnt      <= CNT_LD;
          end
        end
        ACC: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (!we_lat) rdat <= ram_dato;
        end
        DONE: begin
          // a port-0 win leaves the background rotation untouched
          if (win != 2'd0)
            rr_ptr <= (win == 2'd3) ? 2'd1 : win + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign ram_ce = (state == ACC);
  assign ram_oe = ram_ce & ~we_lat;
  assign ram_we = ram_ce & we_lat;
  assign busy   = (state != IDLE);
  assign ack    = (state == DONE) ? (4'b0001 << win) : 4'b0000;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb at ACC_CYC=4 and ACC_CYC=1.
// A transaction-level model predicts each grant; a monitor checks the pins.
module tb_mem_arb;
  localparam int AW = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            port;
    int            start;
    int            done;
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    rd;
  } exp_t;

  function automatic logic [7:0] ram_f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h79;
  endfunction

  task automatic chk(input string nm, input int g,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h want %0h", nm, g, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int A = (g == 0) ? 4 : 1;

    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr;
    logic [31:0]     dati;
    logic [3:0]      ack;
    logic [7:0]      rdat;
    logic            busy;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      ram_dati;
    logic [7:0]      ram_dato;
    logic            ram_ce;
    logic            ram_oe;
    logic            ram_we;

    mem_arb #(.ACC_CYC(A), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we),
      .addr(addr), .dati(dati), .ack(ack), .rdat(rdat),
      .busy(busy), .ram_addr(ram_addr), .ram_dati(ram_dati),
      .ram_dato(ram_dato), .ram_ce(ram_ce), .ram_oe(ram_oe),
      .ram_we(ram_we)
    );

    assign ram_dato = ram_f(ram_addr);

    exp_t       q[$];
    int         acks[$];
    int         ack_cyc[$];
    int         cyc = 0;
    int         m_free = 0;
    int         m_rr = 1;
    logic [7:0] m_rdat = 8'hFF;
    logic [3:0] hold = 4'b0000;
    bit         fin = 1'b0;

    // reference: one grant per free slot, slot length A+2 cycles
    always @(posedge clk) begin
      cyc++;
      if (rst_n !== 1'b1) begin
        q.delete();
        m_free = 0;
        m_rr = 1;
        m_rdat = 8'hFF;
      end else if (cyc >= m_free && req != 4'b0000) begin
        int w;
        exp_t e;
        if (req[0]) w = 0;
        else begin
          w = m_rr;
          while (!req[w]) w = (w == 3) ? 1 : w + 1;
        end
        e.port = w;
        e.start = cyc;
        e.done = cyc + A;
        e.we = we[w];
        e.a = addr[w*AW +: AW];
        e.d = dati[w*8 +: 8];
        if (!e.we) m_rdat = ram_f(e.a);
        e.rd = m_rdat;
        if (w != 0) m_rr = (w == 3) ? 1 : w + 1;
        q.push_back(e);
        m_free = cyc + A + 2;
      end
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        logic act;
        logic bz;
        int ai;
        act = q.size() > 0 && cyc >= q[0].start && cyc < q[0].done;
        bz = q.size() > 0 && cyc >= q[0].start && cyc <= q[0].done;
        chk("busy", g, busy, bz);
        chk("ram_ce", g, ram_ce, act);
        if (act) begin
          chk("ram_addr", g, ram_addr, q[0].a);
          chk("ram_we", g, ram_we, q[0].we);
          chk("ram_oe", g, ram_oe, !q[0].we);
          if (q[0].we) chk("ram_dati", g, ram_dati, q[0].d);
        end else begin
          chk("strobes_off", g, {ram_oe, ram_we}, 0);
        end
        if (ack != 4'b0000) begin
          ai = 0;
          for (int p = 3; p >= 0; p--) if (ack[p]) ai = p;
          acks.push_back(ai);
          ack_cyc.push_back(cyc);
          if (q.size() == 0) chk("spurious_ack", g, ack, 0);
          else begin
            chk("ack_port", g, ack, 32'(1) << q[0].port);
            chk("ack_cycle", g, cyc, q[0].done);
            chk("rdat", g, rdat, q[0].rd);
            void'(q.pop_front());
          end
        end else if (q.size() > 0 && cyc > q[0].done) begin
          chk("missing_ack", g, ack, 32'(1) << q[0].port);
          void'(q.pop_front());
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++)
        if (ack[p] && !hold[p]) req[p] = 1'b0;
    endtask

    task automatic set_port(input int p, input logic w,
                            input logic [AW-1:0] a, input logic [7:0] d);
      we[p] = w;
      addr[p*AW +: AW] = a;
      dati[p*8 +: 8] = d;
    endtask

    task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (acks.size() < n && k < budget) begin
        tick();
        k++;
      end
      if (acks.size() < n) chk("wait_acks", g, acks.size(), n);
    endtask

    task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy || q.size() > 0) && k < budget) begin
        tick();
        k++;
      end
      if (busy || q.size() > 0) chk("wait_idle", g, busy, 0);
    endtask

    initial begin
      rst_n = 1'b0;
      req = 4'b0000;
      we = 4'b0000;
      addr = '0;
      dati = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", g, ack, 0);
      chk("rst_rdat", g, rdat, 8'hFF);
      chk("rst_busy", g, busy, 0);
      chk("rst_strobes", g, {ram_ce, ram_oe, ram_we}, 0);
      chk("rst_ram_addr", g, ram_addr, 0);
      chk("rst_ram_dati", g, ram_dati, 0);
      rst_n = 1'b1;

      acks.delete();
      req = 4'b1111;
      wait_acks(4, 60);
      for (int i = 0; i < 4; i++)
        if (i < acks.size()) chk("prio_order", g, acks[i], i);
      wait_idle(20);
      acks.delete();
      req = 4'b1110;
      wait_acks(1, 20);
      if (acks.size() > 0) chk("rr_wrap", g, acks[0], 1);
      wait_acks(3, 40);
      wait_idle(20);

      set_port(1, 1'b0, 23'h000123, 8'h00);
      acks.delete();
      req[1] = 1'b1;
      wait_acks(1, 30);
      wait_idle(20);
      chk("read_rdat", g, rdat, 8'h5A);

      set_port(2, 1'b1, 23'h400010, 8'hC3);
      acks.delete();
      req[2] = 1'b1;
      wait_acks(1, 30);
      wait_idle(20);
      chk("write_keeps_rdat", g, rdat, 8'h5A);

      hold = 4'b1010;
      acks.delete();
      req = 4'b1010;
      wait_acks(5, 80);
      req = 4'b0000;
      hold = 4'b0000;
      for (int i = 1; i < 5; i++) begin
        if (i < acks.size()) begin
          chk("fair_alt", g, acks[i] != acks[i-1], 1);
          chk("fair_port", g, acks[i] == 1 || acks[i] == 3, 1);
          chk("fair_period", g, ack_cyc[i] - ack_cyc[i-1], A + 2);
        end
      end
      wait_idle(30);

      set_port(0, 1'b0, 23'h0000AB, 8'h00);
      acks.delete();
      req[0] = 1'b1;
      repeat (A > 1 ? 2 : 1) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strobes", g, {ram_ce, ram_oe, ram_we}, 0);
      chk("mid_rst_ack", g, ack, 0);
      chk("mid_rst_rdat", g, rdat, 8'hFF);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_acks(1, 30);
      if (acks.size() > 0) chk("mid_rst_reserve", g, acks[0], 0);
      chk("mid_rst_single_ack", g, acks.size(), 1);
      wait_idle(20);

      set_port(3, 1'b0, 23'h7F0055, 8'h00);
      acks.delete();
      req[3] = 1'b1;
      tick();
      req[3] = 1'b0;
      wait_acks(1, 30);
      repeat (A + 4) tick();
      if (acks.size() > 0) chk("withdrawn_port", g, acks[0], 3);
      chk("withdrawn_once", g, acks.size(), 1);
      chk("withdrawn_idle", g, busy, 0);

      for (int t = 0; t < 900; t++) begin
        if ($urandom_range(0, 49) == 0) hold = 4'($urandom);
        for (int p = 0; p < 4; p++) begin
          set_port(p, 1'($urandom), AW'($urandom), 8'($urandom));
          if (!req[p] && $urandom_range(0, 3) == 0) req[p] = 1'b1;
          else if (req[p] && $urandom_range(0, 15) == 0) req[p] = 1'b0;
        end
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          @(posedge clk);
          @(posedge clk);
          #1;
          chk("rand_rst_rdat", g, rdat, 8'hFF);
          rst_n = 1'b1;
        end
        tick();
      end
      req = 4'b0000;
      hold = 4'b0000;
      wait_idle(60);
      fin = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(cfg[0].fin && cfg[1].fin) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) chk("finish", -1, cfg[0].fin & cfg[1].fin, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
